// File: rtl/spi_led_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_led_ctrl_if
// Description : Frame bus between spi_slave and spi_led_ctrl.
//               i_rx_dv / i_cmd / i_addr / i_payload : received frame
//                 (spi_slave -> controller)
//               o_slv_tx_enb / o_slv_frame : response frame
//                 (controller -> spi_slave)
//               modport slave  : the LED controller side
//               modport master : the spi_slave (frame source) side
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_led_ctrl_if #(
  parameter int CMD_W     = 2,
  parameter int ADDR_W    = 3,
  parameter int PAYLOAD_W = 8,
  parameter int FRAME_W   = CMD_W + ADDR_W + PAYLOAD_W
);
  logic                 i_rx_dv;
  logic [CMD_W-1:0]     i_cmd;
  logic [ADDR_W-1:0]    i_addr;
  logic [PAYLOAD_W-1:0] i_payload;
  logic                 o_slv_tx_enb;
  logic [FRAME_W-1:0]   o_slv_frame;

  modport slave (
    input  i_rx_dv, i_cmd, i_addr, i_payload,
    output o_slv_tx_enb, o_slv_frame
  );

  modport master (
    output i_rx_dv, i_cmd, i_addr, i_payload,
    input  o_slv_tx_enb, o_slv_frame
  );
endinterface
`default_nettype wire

// File: rtl/spi_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_led_ctrl
// Description : Command executor and PWM bank behind an SPI slave. Frames
//               {cmd, addr, payload} are captured on i_rx_dv and executed
//               once chip select is released. Commands: NOP, LED_SET,
//               LED_READ (loads a response frame for the next transaction)
//               and LED_ALL (broadcast set).
// Ports       : sysclk      - system clock, rising edge
//               rst_n       - asynchronous active-low reset
//               cs          - raw SPI chip select (asynchronous)
//               bus         - frame bus (slave modport)
//               o_cmd_err   - one-cycle pulse, SET/READ to bad address
//               o_busy      - FSM not idle
//               o_pwm       - PWM outputs, bit i drives LED i+1
// Revision    : 1.0 - initial release
// ============================================================================
module spi_led_ctrl #(
  parameter int   NUM_LEDS    = 8,
  parameter int   PWM_BITS    = 7,
  parameter int   CMD_W       = 2,
  parameter int   ADDR_W      = 3,
  parameter int   PAYLOAD_W   = 8,
  parameter int   FRAME_W     = CMD_W + ADDR_W + PAYLOAD_W,
  parameter logic CS_DEASSERT = 1'b1
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                cs,
  spi_led_ctrl_if.slave       bus,
  output logic                o_cmd_err,
  output logic                o_busy,
  output logic [NUM_LEDS-1:0] o_pwm
);

  localparam logic [CMD_W-1:0]  c_CMD_NOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0]  c_CMD_SET  = CMD_W'(1);
  localparam logic [CMD_W-1:0]  c_CMD_READ = CMD_W'(2);
  localparam logic [CMD_W-1:0]  c_CMD_ALL  = CMD_W'(3);
  localparam logic [ADDR_W:0]   c_NUM_LEDS = (ADDR_W + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_TX_ARM  = 2'd2,
    S_TX_HOLD = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // chip-select synchroniser and edge detector
  logic r_cs_meta;
  logic r_cs_s;
  logic r_cs_s_d;
  logic w_cs_start;

  // holding register for the most recent frame
  logic                r_pending;
  logic [CMD_W-1:0]    r_hold_cmd;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [PWM_BITS-1:0] r_hold_bri;

  // frame being executed; frozen so a frame arriving mid-command cannot
  // change the address used by TX_ARM
  logic [CMD_W-1:0]    r_x_cmd;
  logic [ADDR_W-1:0]   r_x_addr;
  logic [PWM_BITS-1:0] r_x_bri;

  logic [PWM_BITS-1:0] r_duty [NUM_LEDS];
  logic [PWM_BITS-1:0] r_cnt;
  logic [NUM_LEDS-1:0] r_pwm;

  logic                 r_tx_enb;
  logic [FRAME_W-1:0]   r_frame;

  logic                 w_start_exec;
  logic                 w_addr_ok;
  logic                 w_exec_set;
  logic                 w_exec_all;
  logic [PWM_BITS-1:0]  w_rx_bri;
  logic [PWM_BITS-1:0]  w_rd_duty;
  logic [PAYLOAD_W-1:0] w_rd_payload;

  assign w_rx_bri   = bus.i_payload[PAYLOAD_W-1 -: PWM_BITS];
  // start of a transaction: cs_s leaves its idle level
  assign w_cs_start = (r_cs_s_d == CS_DEASSERT) && (r_cs_s != CS_DEASSERT);
  // a frame arriving this very cycle counts as pending so execution can
  // start one cycle after i_rx_dv
  assign w_start_exec = (r_state == S_IDLE) && (r_pending || bus.i_rx_dv) &&
                        (r_cs_s == CS_DEASSERT);
  assign w_addr_ok  = ({1'b0, r_x_addr} < c_NUM_LEDS);
  assign w_exec_set = (r_state == S_EXEC) && (r_x_cmd == c_CMD_SET) && w_addr_ok;
  assign w_exec_all = (r_state == S_EXEC) && (r_x_cmd == c_CMD_ALL);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta <= CS_DEASSERT;
      r_cs_s    <= CS_DEASSERT;
      r_cs_s_d  <= CS_DEASSERT;
    end else begin
      r_cs_meta <= cs;
      r_cs_s    <= r_cs_meta;
      r_cs_s_d  <= r_cs_s;
    end
  end

  // FSM state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and combinational outputs
  always_comb begin
    w_next    = r_state;
    o_cmd_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_exec) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_IDLE;
        if (((r_x_cmd == c_CMD_SET) || (r_x_cmd == c_CMD_READ)) && !w_addr_ok) begin
          o_cmd_err = 1'b1;
        end else if (r_x_cmd == c_CMD_READ) begin
          w_next = S_TX_ARM;
        end
      end
      S_TX_ARM: begin
        w_next = S_TX_HOLD;
      end
      S_TX_HOLD: begin
        if (w_cs_start) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  // frame capture; last frame wins
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= 1'b0;
      r_hold_cmd  <= c_CMD_NOP;
      r_hold_addr <= '0;
      r_hold_bri  <= '0;
      r_x_cmd     <= c_CMD_NOP;
      r_x_addr    <= '0;
      r_x_bri     <= '0;
    end else begin
      if (bus.i_rx_dv) begin
        r_hold_cmd  <= bus.i_cmd;
        r_hold_addr <= bus.i_addr;
        r_hold_bri  <= w_rx_bri;
      end
      if (w_start_exec) begin
        r_pending <= 1'b0;
        r_x_cmd   <= bus.i_rx_dv ? bus.i_cmd  : r_hold_cmd;
        r_x_addr  <= bus.i_rx_dv ? bus.i_addr : r_hold_addr;
        r_x_bri   <= bus.i_rx_dv ? w_rx_bri   : r_hold_bri;
      end else if (bus.i_rx_dv) begin
        r_pending <= 1'b1;
      end
    end
  end

  // duty registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_exec_all || (w_exec_set && (r_x_addr == ADDR_W'(i)))) begin
          r_duty[i] <= r_x_bri;
        end
      end
    end
  end

  // read-back mux; out-of-range addresses never reach TX_ARM
  always_comb begin
    w_rd_duty = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (r_x_addr == ADDR_W'(i)) w_rd_duty = r_duty[i];
    end
  end

  assign w_rd_payload = PAYLOAD_W'(w_rd_duty) << (PAYLOAD_W - PWM_BITS);

  // response frame
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_enb <= 1'b0;
      r_frame  <= '0;
    end else begin
      if (r_state == S_TX_ARM) begin
        r_tx_enb <= 1'b1;
        r_frame  <= {c_CMD_READ, r_x_addr, w_rd_payload};
      end else if ((r_state == S_TX_HOLD) && w_cs_start) begin
        r_tx_enb <= 1'b0;
      end
    end
  end

  assign bus.o_slv_tx_enb = r_tx_enb;
  assign bus.o_slv_frame  = r_frame;

  // shared free-running PWM counter, wraps naturally
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pwm
    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        r_pwm[g] <= 1'b0;
      end else begin
        r_pwm[g] <= (r_cnt < r_duty[g]);
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_spi_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_led_ctrl
// Description : Self-checking bench for spi_led_ctrl. Instance A uses the
//               default 8-channel configuration, instance B has 6 channels
//               to exercise out-of-range addresses. A behavioural model
//               keeps the expected duty of every channel as plain integers.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_led_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cs_a;
  logic cs_b;
  logic err_a, busy_a, err_b, busy_b;
  logic [7:0] pwm_a;
  logic [5:0] pwm_b;

  spi_led_ctrl_if #(.CMD_W(2), .ADDR_W(3), .PAYLOAD_W(8)) bus_a ();
  spi_led_ctrl_if #(.CMD_W(2), .ADDR_W(3), .PAYLOAD_W(8)) bus_b ();

  spi_led_ctrl #(.NUM_LEDS(8)) dut_a (
    .sysclk(clk), .rst_n(rst_n), .cs(cs_a), .bus(bus_a.slave),
    .o_cmd_err(err_a), .o_busy(busy_a), .o_pwm(pwm_a)
  );

  spi_led_ctrl #(.NUM_LEDS(6)) dut_b (
    .sysclk(clk), .rst_n(rst_n), .cs(cs_b), .bus(bus_b.slave),
    .o_cmd_err(err_b), .o_busy(busy_b), .o_pwm(pwm_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int duty_a [8];
  int duty_b [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply one frame; returns one cycle after the capturing edge.
  task automatic send(input bit sel_b, input int cmd, input int addr, input int pl);
    tick();
    if (!sel_b) begin
      bus_a.i_rx_dv = 1'b1; bus_a.i_cmd = 2'(cmd); bus_a.i_addr = 3'(addr); bus_a.i_payload = 8'(pl);
    end else begin
      bus_b.i_rx_dv = 1'b1; bus_b.i_cmd = 2'(cmd); bus_b.i_addr = 3'(addr); bus_b.i_payload = 8'(pl);
    end
    tick();
    bus_a.i_rx_dv = 1'b0;
    bus_b.i_rx_dv = 1'b0;
  endtask

  // Model update for one executed frame: brightness is the top 7 payload bits.
  task automatic model_a(input int cmd, input int addr, input int pl);
    if (cmd == 1) duty_a[addr] = pl / 2;
    if (cmd == 3) for (int i = 0; i < 8; i++) duty_a[i] = pl / 2;
  endtask

  // Over any 128 consecutive cycles a channel is high exactly duty times.
  task automatic check_pwm_all();
    int ca [8];
    int cb [6];
    for (int i = 0; i < 8; i++) ca[i] = 0;
    for (int i = 0; i < 6; i++) cb[i] = 0;
    tick(4);
    repeat (128) begin
      tick();
      for (int i = 0; i < 8; i++) ca[i] += int'(pwm_a[i]);
      for (int i = 0; i < 6; i++) cb[i] += int'(pwm_b[i]);
    end
    for (int i = 0; i < 8; i++) check($sformatf("pwm_a[%0d]", i), 32'(ca[i]), 32'(duty_a[i]));
    for (int i = 0; i < 6; i++) check($sformatf("pwm_b[%0d]", i), 32'(cb[i]), 32'(duty_b[i]));
  endtask

  // Expected read-back frame {2'b10, addr, duty MSB-aligned}.
  function automatic logic [31:0] rd_frame(input int addr, input int duty);
    return 32'(2 * 2048 + addr * 256 + duty * 2);
  endfunction

  initial begin
    rst_n = 1'b0;
    cs_a  = 1'b1;
    cs_b  = 1'b1;
    bus_a.i_rx_dv = 1'b0; bus_a.i_cmd = '0; bus_a.i_addr = '0; bus_a.i_payload = '0;
    bus_b.i_rx_dv = 1'b0; bus_b.i_cmd = '0; bus_b.i_addr = '0; bus_b.i_payload = '0;
    for (int i = 0; i < 8; i++) duty_a[i] = 0;
    for (int i = 0; i < 6; i++) duty_b[i] = 0;

    // ---- reset state ----
    tick(3);
    check("rst_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd0);
    check("rst_frame", 32'(bus_a.o_slv_frame), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_pwm", 32'(pwm_a), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // ---- SET addr 3, latency of EXEC ----
    send(0, 1, 3, 8'hFE); model_a(1, 3, 8'hFE);
    check("set_exec_busy", 32'(busy_a), 32'd1);
    check("set_exec_err", 32'(err_a), 32'd0);
    tick();
    check("set_idle_busy", 32'(busy_a), 32'd0);
    check_pwm_all();

    // ---- ALL 0x80 then SET addr 0 to 0 ----
    send(0, 3, 6, 8'h80); model_a(3, 6, 8'h80);
    check_pwm_all();
    send(0, 1, 0, 8'h00); model_a(1, 0, 8'h00);
    check_pwm_all();

    // ---- READ with a SET captured during TX_HOLD ----
    send(0, 1, 5, 8'h54); model_a(1, 5, 8'h54);
    tick();
    send(0, 2, 5, 0);
    tick();
    check("rd_arm_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd0);
    tick();
    check("rd_hold_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd1);
    check("rd_frame", 32'(bus_a.o_slv_frame), rd_frame(5, duty_a[5]));
    send(0, 1, 6, 8'h20);
    tick(3);
    check("rd_hold_stays", 32'(bus_a.o_slv_tx_enb), 32'd1);
    check("rd_hold_busy", 32'(busy_a), 32'd1);
    cs_a = 1'b0;
    tick(2);
    check("rd_edge_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd1);
    tick();
    check("rd_drop_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd0);
    check("rd_drop_busy", 32'(busy_a), 32'd0);
    check("rd_frame_held", 32'(bus_a.o_slv_frame), rd_frame(5, duty_a[5]));
    tick(3);
    check("rd_cs_low_idle", 32'(busy_a), 32'd0);
    cs_a = 1'b1;
    model_a(1, 6, 8'h20);
    check_pwm_all();

    // ---- two frames while cs asserted: last wins, start after cs_s idle ----
    cs_a = 1'b0;
    tick(3);
    send(0, 1, 1, 8'hFE);
    send(0, 1, 2, 8'h40);
    tick(3);
    check("pend_cs_low_busy", 32'(busy_a), 32'd0);
    cs_a = 1'b1;
    tick(2);
    check("pend_sync_busy", 32'(busy_a), 32'd0);
    tick();
    check("pend_exec_busy", 32'(busy_a), 32'd1);
    model_a(1, 2, 8'h40);
    check_pwm_all();

    // ---- 6-channel instance: out-of-range addresses ----
    send(1, 1, 2, 8'h66); duty_b[2] = 8'h66 / 2;
    check("b_set_ok_err", 32'(err_b), 32'd0);
    tick();
    send(1, 1, 7, 8'hFE);
    check("b_set7_err", 32'(err_b), 32'd1);
    tick();
    check("b_set7_err_end", 32'(err_b), 32'd0);
    send(1, 2, 6, 0);
    check("b_rd6_err", 32'(err_b), 32'd1);
    tick();
    check("b_rd6_err_end", 32'(err_b), 32'd0);
    check("b_rd6_busy", 32'(busy_b), 32'd0);
    tick(2);
    check("b_rd6_tx_enb", 32'(bus_b.o_slv_tx_enb), 32'd0);
    check_pwm_all();

    // ---- randomized command stream on instance A ----
    for (int k = 0; k < 24; k++) begin
      int c;
      int ad;
      int pl;
      c  = int'($urandom_range(0, 3));
      ad = int'($urandom_range(0, 7));
      pl = int'($urandom_range(0, 255));
      send(0, c, ad, pl);
      check("rnd_exec_busy", 32'(busy_a), 32'd1);
      check("rnd_exec_err", 32'(err_a), 32'd0);
      model_a(c, ad, pl);
      if (c == 2) begin
        tick(2);
        check("rnd_rd_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd1);
        check("rnd_rd_frame", 32'(bus_a.o_slv_frame), rd_frame(ad, duty_a[ad]));
        cs_a = 1'b0;
        tick(3);
        check("rnd_rd_done", 32'({bus_a.o_slv_tx_enb, busy_a}), 32'd0);
        cs_a = 1'b1;
        tick(3);
      end else begin
        tick();
        check("rnd_idle_busy", 32'(busy_a), 32'd0);
      end
      if ((k % 8) == 7) check_pwm_all();
    end

    // ---- asynchronous reset while in TX_HOLD ----
    send(0, 3, 0, 8'hC8); model_a(3, 0, 8'hC8);
    tick();
    send(0, 2, 4, 0);
    tick(2);
    check("arst_pre_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_enb", 32'(bus_a.o_slv_tx_enb), 32'd0);
    check("arst_pwm", 32'(pwm_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) duty_a[i] = 0;
    for (int i = 0; i < 6; i++) duty_b[i] = 0;
    check_pwm_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_led_ctrl.md
Name: spi_led_ctrl

Overview:
- Parametrised command executor and PWM bank. Sits between `spi_slave` frame outputs and the board LED pins.
- Decodes received {cmd, addr, payload} frames and executes them once CS is released. Supports per-LED set, broadcast set and LED read-back.
- Read-back loads a response frame into `spi_slave` for the next transaction.
- Generalises the fixed 8-LED/7-bit top to N channels and configurable PWM resolution.

Parameters:
- NUM_LEDS, 8, number of PWM channels (1..2^ADDR_W)
- PWM_BITS, 7, duty/counter width; must be <= PAYLOAD_W
- CMD_W, 2, command field width
- ADDR_W, 3, address field width
- PAYLOAD_W, 8, payload field width
- FRAME_W, CMD_W+ADDR_W+PAYLOAD_W, response frame width
- CS_DEASSERT, 1, idle level of cs

Ports:
- sysclk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  raw SPI chip select pin, asynchronous to sysclk
- i_rx_dv  in  1  one-cycle frame-valid pulse from spi_slave, sysclk domain
- i_cmd  in  CMD_W  received command
- i_addr  in  ADDR_W  received LED address
- i_payload  in  PAYLOAD_W  received payload
- o_slv_tx_enb  out  1  response frame valid, to spi_slave slv_tx_enb
- o_slv_frame  out  FRAME_W  response frame, to spi_slave i_slv_frame
- o_cmd_err  out  1  one-cycle pulse: SET/READ to address >= NUM_LEDS
- o_busy  out  1  high whenever FSM not in IDLE
- o_pwm  out  NUM_LEDS  PWM outputs, bit i drives LED i+1

Behaviour:
- Reset (rst_n low, any time, including mid-FSM):
  - all duty registers 0, o_pwm 0, PWM counter 0
  - o_slv_tx_enb 0, o_slv_frame 0, o_cmd_err 0
  - pending flag cleared, FSM to IDLE
- cs is synchronised with 2 flops (cs_s); a falling edge of cs_s is detected from a registered copy.
- Capture:
  - i_rx_dv high in any state latches {cmd, addr, payload} into a holding register and sets pending.
  - A later i_rx_dv overwrites the holding register; last frame wins.
- Commands: 0 NOP, 1 LED_SET, 2 LED_READ, 3 LED_ALL.
- Brightness field = payload[PAYLOAD_W-1 -: PWM_BITS] (MSB-aligned).
- FSM states: IDLE, EXEC, TX_ARM, TX_HOLD.
  - IDLE -> EXEC when pending && cs_s==CS_DEASSERT; pending cleared on this transition.
  - EXEC, one cycle:
    - SET with addr < NUM_LEDS: duty[addr] <= brightness.
    - ALL: every duty <= brightness; addr ignored.
    - NOP: no action.
    - SET/READ with addr >= NUM_LEDS: o_cmd_err pulses in the EXEC cycle, no register change.
    - Next state is TX_ARM for a valid READ, else IDLE.
  - TX_ARM, one cycle: o_slv_frame <= {2'd2, addr, duty[addr] MSB-aligned, zero-padded LSBs}; o_slv_tx_enb <= 1. -> TX_HOLD.
  - TX_HOLD:
    - o_slv_tx_enb held high until a falling edge of cs_s (the master starts the read transaction).
    - o_slv_tx_enb drops the cycle after that edge; o_slv_frame holds its value. -> IDLE.
    - i_rx_dv during TX_HOLD is captured; it executes only after returning to IDLE.
- Latency: i_rx_dv at cycle t with cs_s already deasserted -> pending t+1, EXEC t+1, duty updated t+2, o_pwm reflects it from t+3.
- PWM:
  - A free-running PWM_BITS counter is shared by all channels and wraps at 2^PWM_BITS-1 -> 0.
  - o_pwm[i] is registered: o_pwm[i] <= (cnt < duty[i]).
  - duty 0: constantly low. duty D: exactly D high cycles per 2^PWM_BITS period.
  - A duty change takes effect at the next counter compare; there is no period alignment.
- Addresses in NUM_LEDS..2^ADDR_W-1 never alias onto a real channel.

Test Plan:
- Reset, then SET addr 3 payload 8'hFE, cs high -> duty[3]=127, o_pwm[3] high 127 of every 128 cycles, other channels 0.
- ALL payload 8'h80 -> every o_pwm[i] high exactly 64 of every 128 cycles; subsequent SET addr 0 payload 0 -> o_pwm[0] constantly low, others unchanged.
- After SET addr 5 payload 8'h54: READ addr 5 -> TX_ARM, o_slv_frame={2'b10,3'd5,8'h54}, o_slv_tx_enb=1 held until a cs falling edge, then 0 one cycle later; o_busy low afterwards.
- Instance with NUM_LEDS=6: SET addr 7 -> o_cmd_err one-cycle pulse, no duty change; READ addr 6 -> o_cmd_err pulse, o_slv_tx_enb stays 0.
- i_rx_dv while cs low -> FSM stays IDLE with pending set; execution starts on the cycle after cs_s deasserts. Two i_rx_dv before release -> only the second executes.
- rst_n low during TX_HOLD -> o_slv_tx_enb and o_pwm 0 immediately (asynchronous), FSM IDLE, all duty 0 after release.
